// File: rtl/frame_diff_reader.sv
//------------------------------------------------------------------------------
// frame_diff_reader
//
// Reads two SDRAM read-side FIFOs in lockstep. Read port 1 holds the current
// frame and read port 2 holds the previous frame, both RGB565. For each pixel
// pair it forms a simple luma (R5+G6+B5), takes the absolute difference, and
// flags the pixel as motion when the difference is strictly above THRESH.
// Motion pixels are replaced by MARK_COLOR in the output stream. The number of
// motion pixels in a frame is published on MOTION_CNT at the end of the frame.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   Sdram_Init_Done   frames may only start once SDRAM init is complete
//   FRAME_START       single-cycle request to process one frame
//   THRESH            motion threshold on the luma difference
//   RD1_DATA/EMPTY    current-frame FIFO q / empty
//   RD1, RD1_LOAD     current-frame FIFO rdreq / clear+address reload
//   RD2_DATA/EMPTY    previous-frame FIFO q / empty
//   RD2, RD2_LOAD     previous-frame FIFO rdreq / clear+address reload
//   PIX_DATA          output pixel (MARK_COLOR for motion pixels)
//   PIX_VALID         PIX_DATA/PIX_MOTION valid this cycle
//   PIX_MOTION        current output pixel is a motion pixel
//   MOTION_CNT        motion pixels counted in the last completed frame
//   FRAME_DONE        one-cycle pulse at end of frame
//   BUSY              high whenever a frame is in progress
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module frame_diff_reader #(
   parameter int          FRAME_PIXELS = 307200,
   parameter int          PIX_W        = 19,
   parameter int          LOAD_CYCLES  = 4,
   parameter logic [15:0] MARK_COLOR   = 16'hF800
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             Sdram_Init_Done,
   input  logic             FRAME_START,
   input  logic [6:0]       THRESH,
   input  logic [15:0]      RD1_DATA,
   input  logic             RD1_EMPTY,
   output logic             RD1,
   output logic             RD1_LOAD,
   input  logic [15:0]      RD2_DATA,
   input  logic             RD2_EMPTY,
   output logic             RD2,
   output logic             RD2_LOAD,
   output logic [15:0]      PIX_DATA,
   output logic             PIX_VALID,
   output logic             PIX_MOTION,
   output logic [PIX_W:0]   MOTION_CNT,
   output logic             FRAME_DONE,
   output logic             BUSY
);

   localparam int CNT_W = 16;
   localparam int MC_W  = PIX_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FILL,
      STREAM,
      DRAIN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cycCnt_q;
   logic [PIX_W-1:0]  pixCnt_q;
   logic [MC_W-1:0]   runCnt_q, runCnt_d;
   logic [MC_W-1:0]   motionCnt_q;

   logic              rdReq;
   logic              loadOn;
   logic              frameDone;
   logic              leavingLoad;

   logic              rdDly_q;
   logic              s1Valid_q;
   logic [6:0]        s1Diff_q;
   logic [15:0]       s1Pix_q;
   logic              pixValid_q;
   logic              pixMotion_q;
   logic [15:0]       pixData_q;

   logic [6:0]        luma1, luma2, lumaDiff;

   // Simple luma: plain sum of the three colour fields, at most 31+63+31=125.
   function automatic logic [6:0] luma(input logic [15:0] p);
      return 7'(p[15:11]) + 7'(p[10:5]) + 7'(p[4:0]);
   endfunction

   // Next-state and combinational outputs. The read request is a pure
   // function of the state and both empty flags so RD1 and RD2 are the same
   // signal and the two FIFOs can never drift apart.
   always_comb begin
      state_d   = state_q;
      rdReq     = 1'b0;
      loadOn    = 1'b0;
      frameDone = 1'b0;
      case (state_q)
         IDLE: begin
            if (FRAME_START && Sdram_Init_Done) state_d = LOAD;
         end
         LOAD: begin
            loadOn = 1'b1;
            if (cycCnt_q == CNT_W'(LOAD_CYCLES - 1)) state_d = FILL;
         end
         FILL: begin
            if (!RD1_EMPTY && !RD2_EMPTY) state_d = STREAM;
         end
         STREAM: begin
            rdReq = ~RD1_EMPTY & ~RD2_EMPTY;
            if (rdReq && (pixCnt_q == PIX_W'(FRAME_PIXELS - 1))) state_d = DRAIN;
         end
         DRAIN: begin
            // Three cycles match the pipeline depth behind the last read.
            if (cycCnt_q == CNT_W'(2)) state_d = DONE;
         end
         DONE: begin
            frameDone = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign leavingLoad = (state_q == LOAD) && (state_d == FILL);

   // Running motion count: restarted at the start of each frame, saturating.
   always_comb begin
      runCnt_d = runCnt_q;
      if (leavingLoad) begin
         runCnt_d = '0;
      end else if (pixValid_q && pixMotion_q && (runCnt_q != {MC_W{1'b1}})) begin
         runCnt_d = runCnt_q + MC_W'(1);
      end
   end

   // State register plus the per-state cycle counter used by LOAD and DRAIN.
   // The counter restarts on every state change so each timed state begins
   // counting from zero.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         cycCnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) cycCnt_q <= '0;
         else                    cycCnt_q <= cycCnt_q + CNT_W'(1);
      end
   end

   // Pixel and motion counters. MOTION_CNT is loaded on entry to DONE from
   // the next-count value, so the last pixel of the frame (which becomes
   // visible in the final DRAIN cycle) is already included while FRAME_DONE
   // is high.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pixCnt_q    <= '0;
         runCnt_q    <= '0;
         motionCnt_q <= '0;
      end else begin
         if (leavingLoad)  pixCnt_q <= '0;
         else if (rdReq)   pixCnt_q <= pixCnt_q + PIX_W'(1);
         runCnt_q <= runCnt_d;
         if ((state_q == DRAIN) && (state_d == DONE)) motionCnt_q <= runCnt_d;
      end
   end

   assign luma1    = luma(RD1_DATA);
   assign luma2    = luma(RD2_DATA);
   assign lumaDiff = (luma1 >= luma2) ? (luma1 - luma2) : (luma2 - luma1);

   // Three-stage pixel pipeline. rdDly_q marks the cycle in which the FIFO q
   // carries the word requested one cycle earlier; the difference is captured
   // then, and the threshold compare and colour substitution happen one cycle
   // later, giving a fixed latency of three cycles from rdreq to PIX_VALID.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rdDly_q     <= 1'b0;
         s1Valid_q   <= 1'b0;
         s1Diff_q    <= '0;
         s1Pix_q     <= '0;
         pixValid_q  <= 1'b0;
         pixMotion_q <= 1'b0;
         pixData_q   <= '0;
      end else begin
         rdDly_q   <= rdReq;
         s1Valid_q <= rdDly_q;
         if (rdDly_q) begin
            s1Diff_q <= lumaDiff;
            s1Pix_q  <= RD1_DATA;
         end
         pixValid_q <= s1Valid_q;
         if (s1Valid_q) begin
            pixMotion_q <= (s1Diff_q > THRESH);
            pixData_q   <= (s1Diff_q > THRESH) ? MARK_COLOR : s1Pix_q;
         end else begin
            pixMotion_q <= 1'b0;
            pixData_q   <= '0;
         end
      end
   end

   assign RD1        = rdReq;
   assign RD2        = rdReq;
   assign RD1_LOAD   = loadOn;
   assign RD2_LOAD   = loadOn;
   assign PIX_DATA   = pixData_q;
   assign PIX_VALID  = pixValid_q;
   assign PIX_MOTION = pixMotion_q;
   assign MOTION_CNT = motionCnt_q;
   assign FRAME_DONE = frameDone;
   assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_frame_diff_reader.sv
//------------------------------------------------------------------------------
// tb_frame_diff_reader
//
// Directed bench for frame_diff_reader with a 16-pixel frame. Two queue-based
// FIFO models feed the DUT in normal (registered q) mode. A monitor compares
// every output pixel against an expected queue filled when the FIFOs are
// loaded, and checks rdreq-to-PIX_VALID latency and RD1/RD2 agreement.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_frame_diff_reader;

   localparam int FP = 16;
   localparam int PW = 5;
   localparam int LC = 4;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          Sdram_Init_Done;
   logic          FRAME_START;
   logic [6:0]    THRESH;
   logic [15:0]   RD1_DATA;
   logic          RD1_EMPTY;
   logic          RD1;
   logic          RD1_LOAD;
   logic [15:0]   RD2_DATA;
   logic          RD2_EMPTY;
   logic          RD2;
   logic          RD2_LOAD;
   logic [15:0]   PIX_DATA;
   logic          PIX_VALID;
   logic          PIX_MOTION;
   logic [PW:0]   MOTION_CNT;
   logic          FRAME_DONE;
   logic          BUSY;

   frame_diff_reader #(
      .FRAME_PIXELS (FP),
      .PIX_W        (PW),
      .LOAD_CYCLES  (LC),
      .MARK_COLOR   (16'hF800)
   ) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .Sdram_Init_Done (Sdram_Init_Done),
      .FRAME_START     (FRAME_START),
      .THRESH          (THRESH),
      .RD1_DATA        (RD1_DATA),
      .RD1_EMPTY       (RD1_EMPTY),
      .RD1             (RD1),
      .RD1_LOAD        (RD1_LOAD),
      .RD2_DATA        (RD2_DATA),
      .RD2_EMPTY       (RD2_EMPTY),
      .RD2             (RD2),
      .RD2_LOAD        (RD2_LOAD),
      .PIX_DATA        (PIX_DATA),
      .PIX_VALID       (PIX_VALID),
      .PIX_MOTION      (PIX_MOTION),
      .MOTION_CNT      (MOTION_CNT),
      .FRAME_DONE      (FRAME_DONE),
      .BUSY            (BUSY)
   );

   // 100 MHz clock
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [15:0] p1;
      logic [15:0] p2;
      logic [15:0] expData;
      logic        expMotion;
   } vec_t;

   typedef struct packed {
      logic [15:0] d;
      logic        m;
   } exp_t;

   vec_t        vecs [16];
   logic [15:0] q1 [$];
   logic [15:0] q2 [$];
   exp_t        expQ [$];
   int          rdCycQ [$];

   int   push1 = 0, push2 = 0, pop1 = 0, pop2 = 0;
   int   cyc = 0;
   int   checks = 0, errors = 0;
   int   rdCount = 0, loadCount = 0, doneCount = 0, validCount = 0;
   logic force2 = 1'b0;
   logic toggleMode = 1'b0;

   assign RD1_EMPTY = (push1 == pop1);
   assign RD2_EMPTY = (push2 == pop2) || force2;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Push one pixel pair into the FIFO models along with its expected output.
   task automatic applyStimulus(input logic [15:0] p1, input logic [15:0] p2,
                                input logic [15:0] d, input logic m);
      exp_t e;
      q1.push_back(p1);
      q2.push_back(p2);
      push1++;
      push2++;
      e.d = d;
      e.m = m;
      expQ.push_back(e);
   endtask

   task automatic flushModels();
      q1.delete();
      q2.delete();
      push1 = pop1;
      push2 = pop2;
      expQ.delete();
      rdCycQ.delete();
   endtask

   // Start a frame, wait for FRAME_DONE, and check per-frame totals.
   task automatic runFrame(input string name, input int expCnt, input bit midStart);
      int  guard;
      bit  pulsed;
      bit  seenDone;
      loadCount  = 0;
      doneCount  = 0;
      validCount = 0;
      rdCount    = 0;
      @(negedge CLK);
      FRAME_START = 1'b1;
      @(negedge CLK);
      FRAME_START = 1'b0;
      guard    = 0;
      pulsed   = 1'b0;
      seenDone = 1'b0;
      while (!seenDone && guard < 400) begin
         @(negedge CLK);
         guard++;
         if (midStart && !pulsed && rdCount >= 5) begin
            FRAME_START = 1'b1;
            pulsed      = 1'b1;
         end else begin
            FRAME_START = 1'b0;
         end
         if (FRAME_DONE) begin
            seenDone = 1'b1;
            checkOutput({name, "_motion_cnt_at_done"}, 32'(MOTION_CNT), expCnt);
         end
      end
      FRAME_START = 1'b0;
      if (!seenDone) checkOutput({name, "_done_timeout"}, 0, 1);
      repeat (10) @(negedge CLK);
      checkOutput({name, "_done_pulses"}, doneCount, 1);
      checkOutput({name, "_valid_pixels"}, validCount, FP);
      checkOutput({name, "_reads"}, rdCount, FP);
      checkOutput({name, "_load_cycles"}, loadCount, LC);
      checkOutput({name, "_busy_after"}, 32'(BUSY), 0);
      checkOutput({name, "_pixels_left"}, expQ.size(), 0);
      checkOutput({name, "_motion_cnt_hold"}, 32'(MOTION_CNT), expCnt);
   endtask

   // FIFO models in normal mode: q updates on the clock edge that accepts rdreq.
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (RD1 && q1.size() > 0) begin
         RD1_DATA <= q1.pop_front();
         pop1     <= pop1 + 1;
      end
      if (RD2 && q2.size() > 0) begin
         RD2_DATA <= q2.pop_front();
         pop2     <= pop2 + 1;
      end
   end

   // Previous-frame FIFO empty flag toggling, changed just after the edge.
   initial begin
      forever begin
         @(posedge CLK);
         #1;
         force2 = toggleMode ? ~force2 : 1'b0;
      end
   end

   // Output monitor sampled on the falling edge.
   always @(negedge CLK) begin
      exp_t e;
      int   c;
      checkOutput("rd1_eq_rd2", 32'(RD1), 32'(RD2));
      if (RD1) begin
         rdCount++;
         rdCycQ.push_back(cyc);
      end
      if (RD1_LOAD) loadCount++;
      if (FRAME_DONE) doneCount++;
      if (PIX_VALID) begin
         validCount++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected_pixel", 1, 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("pix_data", 32'(PIX_DATA), 32'(e.d));
            checkOutput("pix_motion", 32'(PIX_MOTION), 32'(e.m));
         end
         if (rdCycQ.size() == 0) begin
            checkOutput("latency_no_read", 1, 0);
         end else begin
            c = rdCycQ.pop_front();
            checkOutput("latency", cyc - c, 3);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;

      // Mixed-pattern frame, THRESH=20. Y = R5+G6+B5.
      vecs[0]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0};  // d=0
      vecs[1]  = '{16'h001F, 16'h0000, 16'hF800, 1'b1};  // 31-0
      vecs[2]  = '{16'h0000, 16'h001F, 16'hF800, 1'b1};  // |0-31|
      vecs[3]  = '{16'h0015, 16'h0000, 16'hF800, 1'b1};  // 21 > 20
      vecs[4]  = '{16'h0014, 16'h0000, 16'h0014, 1'b0};  // 20 not > 20
      vecs[5]  = '{16'h07E0, 16'h001F, 16'hF800, 1'b1};  // 63-31=32
      vecs[6]  = '{16'hF800, 16'h001F, 16'hF800, 1'b0};  // 31-31=0, pixel itself red
      vecs[7]  = '{16'h1234, 16'h0013, 16'h1234, 1'b0};  // 39-19=20
      vecs[8]  = '{16'h1234, 16'h0012, 16'hF800, 1'b1};  // 39-18=21
      vecs[9]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};  // 125-125
      vecs[10] = '{16'hFFFF, 16'h07E0, 16'hF800, 1'b1};  // 125-63=62
      vecs[11] = '{16'h0841, 16'h0000, 16'h0841, 1'b0};  // 4
      vecs[12] = '{16'h0000, 16'h0841, 16'h0000, 1'b0};  // 4
      vecs[13] = '{16'hA5A5, 16'h5A5A, 16'hA5A5, 1'b0};  // 70-55=15
      vecs[14] = '{16'h5A5A, 16'h0000, 16'hF800, 1'b1};  // 55
      vecs[15] = '{16'h0000, 16'hA5A5, 16'hF800, 1'b1};  // 70

      RESET           = 1'b1;
      Sdram_Init_Done = 1'b0;
      FRAME_START     = 1'b0;
      THRESH          = 7'd0;
      RD1_DATA        = 16'h0000;
      RD2_DATA        = 16'h0000;

      repeat (2) @(negedge CLK);
      checkOutput("reset_ctrl_outputs",
                  32'({RD1, RD2, RD1_LOAD, RD2_LOAD, PIX_VALID, PIX_MOTION, FRAME_DONE, BUSY}), 0);
      checkOutput("reset_pix_data", 32'(PIX_DATA), 0);
      checkOutput("reset_motion_cnt", 32'(MOTION_CNT), 0);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);

      // FRAME_START before SDRAM init is complete must be ignored.
      loadCount   = 0;
      FRAME_START = 1'b1;
      @(negedge CLK);
      FRAME_START = 1'b0;
      repeat (4) @(negedge CLK);
      checkOutput("no_init_busy", 32'(BUSY), 0);
      checkOutput("no_init_load", loadCount, 0);
      Sdram_Init_Done = 1'b1;

      // Identical frames, with a second FRAME_START during STREAM.
      $display("[TB] frame: identical 0x1234 with mid-stream FRAME_START");
      THRESH = 7'd0;
      for (int i = 0; i < FP; i++) applyStimulus(16'h1234, 16'h1234, 16'h1234, 1'b0);
      runFrame("identical", 0, 1'b1);

      // Table-driven mixed frame.
      $display("[TB] frame: table vectors, THRESH=20");
      THRESH = 7'd20;
      for (int i = 0; i < FP; i++)
         applyStimulus(vecs[i].p1, vecs[i].p2, vecs[i].expData, vecs[i].expMotion);
      runFrame("table", 8, 1'b0);

      // Maximum difference just above threshold.
      $display("[TB] frame: 0xFFFF vs 0x0000, THRESH=124");
      THRESH = 7'd124;
      for (int i = 0; i < FP; i++) applyStimulus(16'hFFFF, 16'h0000, 16'hF800, 1'b1);
      runFrame("thr124", 16, 1'b0);

      // Reset after 8 reads of a frame that would otherwise count motion.
      $display("[TB] frame: reset mid-stream");
      for (int i = 0; i < FP; i++) applyStimulus(16'hFFFF, 16'h0000, 16'hF800, 1'b1);
      doneCount = 0;
      rdCount   = 0;
      @(negedge CLK);
      FRAME_START = 1'b1;
      @(negedge CLK);
      FRAME_START = 1'b0;
      guard = 0;
      while (rdCount < 8 && guard < 200) begin
         @(negedge CLK);
         guard++;
      end
      if (rdCount < 8) checkOutput("reset_wait_reads_timeout", 0, 1);
      checkOutput("pre_reset_rd_active", 32'(RD1), 1);
      #2;
      RESET = 1'b1;
      #1;
      checkOutput("mid_reset_ctrl_outputs",
                  32'({RD1, RD2, RD1_LOAD, RD2_LOAD, PIX_VALID, PIX_MOTION, FRAME_DONE, BUSY}), 0);
      checkOutput("mid_reset_pix_data", 32'(PIX_DATA), 0);
      checkOutput("mid_reset_motion_cnt", 32'(MOTION_CNT), 0);
      flushModels();
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      repeat (5) @(negedge CLK);
      checkOutput("after_reset_no_done", doneCount, 0);
      checkOutput("after_reset_busy", 32'(BUSY), 0);

      // A full frame after the abort runs normally.
      $display("[TB] frame: full frame after reset");
      for (int i = 0; i < FP; i++) applyStimulus(16'hFFFF, 16'h0000, 16'hF800, 1'b1);
      runFrame("post_reset", 16, 1'b0);

      // Strict compare: difference equal to threshold is not motion.
      $display("[TB] frame: 0xFFFF vs 0x0000, THRESH=125");
      THRESH = 7'd125;
      for (int i = 0; i < FP; i++) applyStimulus(16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);
      runFrame("thr125", 0, 1'b0);

      // Previous-frame FIFO empty toggling: order and latency checked per pixel.
      $display("[TB] frame: RD2_EMPTY toggling");
      THRESH = 7'd124;
      for (int i = 0; i < FP; i++) begin
         logic [15:0] p;
         p = 16'(i);
         applyStimulus(p, 16'h0000, p, 1'b0);
      end
      toggleMode = 1'b1;
      runFrame("toggle", 0, 1'b0);
      toggleMode = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
